// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the IF stage: stall-bus layout, bus widths, reset PC and hold FSM states.
package if_fetch_unit_pkg;

    localparam int STALL_W_DEF = 6;
    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;

    // Bit positions inside the stall bus
    localparam int STALL_PC   = 0;
    localparam int STALL_IFID = 1;
    localparam int STALL_IDEX = 2;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // The PC sits one word before the boot vector so the first fetch lands on 32'hBFC0_0000
    localparam logic [31:0] RESET_PC_DEF = 32'hBFBF_FFFC;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/if_inst_hold.sv
// Keeps the instruction seen by ID stable while ID is frozen, and turns bubbles into NOPs.
module if_inst_hold
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_ifid,
    input  logic        stall_idex,
    input  logic        id_vld,
    input  logic [31:0] sram_rdata,
    output logic [31:0] id_inst
);

    hold_state_e state_q;
    logic [31:0] hold_q;
    logic        id_frozen_s;

    assign id_frozen_s = (stall_ifid == STOP) && (stall_idex == STOP);

    // Hold FSM: capture the word ID is looking at when it freezes, release on advance or bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOLD_EMPTY;
            hold_q  <= 32'h0000_0000;
        end else begin
            case (state_q)
                HOLD_EMPTY: begin
                    if (id_frozen_s) begin
                        state_q <= HOLD_FULL;
                        hold_q  <= id_inst;
                    end else begin
                        state_q <= HOLD_EMPTY;
                    end
                end
                HOLD_FULL: begin
                    if (id_frozen_s) begin
                        state_q <= HOLD_FULL;
                    end else begin
                        state_q <= HOLD_EMPTY;
                    end
                end
                default: begin
                    state_q <= HOLD_EMPTY;
                end
            endcase
        end
    end

    // Instruction presented to ID decode
    always_comb begin
        if (!id_vld) begin
            id_inst = 32'h0000_0000;
        end else if (state_q == HOLD_FULL) begin
            id_inst = hold_q;
        end else begin
            id_inst = sram_rdata;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: PC register, instruction-SRAM request, ID-valid shadow
// and fetch counter; the held/NOP instruction for ID comes from if_inst_hold.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          STALL_W  = STALL_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata,
    output logic [31:0]            id_inst,
    output logic [31:0]            fetch_cnt
);

    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        id_vld_q, id_vld_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        br_e_s;
    logic [31:0] br_addr_s;
    logic        stall_unused_s;

    assign br_e_s         = br_bus[32];
    assign br_addr_s      = br_bus[31:0];
    assign stall_unused_s = ^stall[STALL_W-1:STALL_IDEX+1];

    // Next PC: a redirect only takes effect when the PC is allowed to advance
    always_comb begin
        pc_d        = pc_q;
        ce_d        = ce_q;
        fetch_cnt_d = fetch_cnt_q;
        if (stall[STALL_PC] == NO_STOP) begin
            ce_d        = 1'b1;
            pc_d        = br_e_s ? br_addr_s : (pc_q + PC_STEP);
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            pc_d        = pc_q;
            ce_d        = ce_q;
            fetch_cnt_d = fetch_cnt_q;
        end
    end

    // Shadow of the ID input register's valid bit
    always_comb begin
        id_vld_d = id_vld_q;
        if (stall[STALL_IFID] == NO_STOP) begin
            id_vld_d = ce_q;
        end else if (stall[STALL_IDEX] == NO_STOP) begin
            id_vld_d = 1'b0;
        end else begin
            id_vld_d = id_vld_q;
        end
    end

    // PC, fetch-enable, ID-valid and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            id_vld_q    <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            id_vld_q    <= id_vld_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // The bus reads as all-zero until the first fetch has been issued
    always_comb begin
        if (ce_q) begin
            if_to_id_bus = {1'b1, pc_q};
        end else begin
            if_to_id_bus = {IF_TO_ID_WD{1'b0}};
        end
    end

    assign inst_sram_en    = ce_q;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;
    assign fetch_cnt       = fetch_cnt_q;

    if_inst_hold u_inst_hold (
        .clk        (clk),
        .rst        (rst),
        .stall_ifid (stall[STALL_IFID]),
        .stall_idex (stall[STALL_IDEX]),
        .id_vld     (id_vld_q),
        .sram_rdata (inst_sram_rdata),
        .id_inst    (id_inst)
    );

endmodule
